median_5_window: RTL and testbench

MEDIAN_5_WINDOW -- requirements
Module: median_5_window

---
 rtl/median_5_window.sv | 141 ++++++++++++++
 tb/tb_median_5_window.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_5_window.sv
// Streaming median-of-5 filter.
// Accepted samples shift into a 5-entry window. Once the window is full,
// each further accept launches the window into a two-stage sort pipeline.
// That pipeline produces the median, minimum and maximum of the window.
// Backpressure from out_ready freezes the whole datapath.
module median_5_window #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_median,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max
);

  function automatic logic [WIDTH-1:0] min_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] max_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? b : a;
  endfunction

  // Median of three values: drop the smallest and the largest.
  function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return max_of(min_of(a, b), min_of(max_of(a, b), c));
  endfunction

  logic [WIDTH-1:0] win_0, win_1, win_2, win_3, win_4;  // win_0 is the newest sample
  logic [2:0]       count;
  logic             win_valid;  // window holds a launched snapshot
  logic             s1_valid;

  // Stage 1 partial sort: extremes of entries 0..3, their two middle values, entry 4.
  logic [WIDTH-1:0] s1_lo, s1_hi, s1_mid_a, s1_mid_b, s1_e;

  logic             stall;
  logic             accept;
  logic             launch;

  logic [WIDTH-1:0] p_lo_01, p_hi_01, p_lo_23, p_hi_23;

  assign stall  = out_valid && !out_ready;
  assign accept = in_valid && !stall && !flush;
  // Count 4 becomes 5 on this accept; count 5 stays saturated. Both launch.
  assign launch = accept && (count >= 3'd4);
  // Held high through reset so upstream never sees a spurious block.
  assign in_ready = rst || (!stall && !flush);

  // Sort the pairs (0,1) and (2,3).
  always_comb begin
    p_lo_01 = min_of(win_0, win_1);
    p_hi_01 = max_of(win_0, win_1);
    p_lo_23 = min_of(win_2, win_3);
    p_hi_23 = max_of(win_2, win_3);
  end

  // Window shift register; the oldest entry falls off on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_0 <= {WIDTH{1'b0}};
      win_1 <= {WIDTH{1'b0}};
      win_2 <= {WIDTH{1'b0}};
      win_3 <= {WIDTH{1'b0}};
      win_4 <= {WIDTH{1'b0}};
    end else if (accept) begin
      win_0 <= in_data;
      win_1 <= win_0;
      win_2 <= win_1;
      win_3 <= win_2;
      win_4 <= win_3;
    end
  end

  // Occupancy counter, saturating at a full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 3'd0;
    end else if (flush) begin
      count <= 3'd0;
    end else if (accept && (count != 3'd5)) begin
      count <= count + 3'd1;
    end
  end

  // Valid bits travel with their data and freeze while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      win_valid <= 1'b0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      win_valid <= launch;
      s1_valid  <= win_valid;
      out_valid <= s1_valid;
    end
  end

  // Stage 1: merge the sorted pairs into min, max and the two middle values of entries 0..3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_lo    <= {WIDTH{1'b0}};
      s1_hi    <= {WIDTH{1'b0}};
      s1_mid_a <= {WIDTH{1'b0}};
      s1_mid_b <= {WIDTH{1'b0}};
      s1_e     <= {WIDTH{1'b0}};
    end else if (!stall && win_valid) begin
      s1_lo    <= min_of(p_lo_01, p_lo_23);
      s1_hi    <= max_of(p_hi_01, p_hi_23);
      s1_mid_a <= max_of(p_lo_01, p_lo_23);
      s1_mid_b <= min_of(p_hi_01, p_hi_23);
      s1_e     <= win_4;
    end
  end

  // Stage 2: fold entry 4 in.
  // With entries 0..3 sorted, the median of all five is med3 of the middle pair and entry 4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_median <= {WIDTH{1'b0}};
      out_min    <= {WIDTH{1'b0}};
      out_max    <= {WIDTH{1'b0}};
    end else if (!stall && s1_valid) begin
      out_median <= med3(s1_mid_a, s1_mid_b, s1_e);
      out_min    <= min_of(s1_lo, s1_e);
      out_max    <= max_of(s1_hi, s1_e);
    end
  end

endmodule

// File: tb/tb_median_5_window.sv
// Self-checking bench for median_5_window.
// It runs directed scenarios with constant expectations, then randomized
// traffic checked against a sort-based reference model.
module tb_median_5_window;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_median;
  logic [31:0] out_min;
  logic [31:0] out_max;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] med;
    logic [31:0] mn;
    logic [31:0] mx;
  } res_t;

  logic [31:0] model_win[$];
  res_t        exp_q[$];

  median_5_window #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_median(out_median), .out_min(out_min), .out_max(out_max)
  );

  always #5 clk = ~clk;

  // Reference: sort a copy of the window and read the middle and both ends.
  function automatic res_t ref_result(input logic [31:0] w[$]);
    logic [31:0] s[5];
    logic [31:0] t;
    res_t r;
    for (int i = 0; i < 5; i++) s[i] = w[i];
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    r.med = s[2]; r.mn = s[0]; r.mx = s[4];
    return r;
  endfunction

  // Global model used by the random scenario: sliding window plus pending results.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_win.delete();
      exp_q.delete();
    end else if (flush) begin
      model_win.delete();
      exp_q.delete();
    end else if (in_valid && !(out_valid && !out_ready)) begin
      model_win.push_back(in_data);
      if (model_win.size() > 5) void'(model_win.pop_front());
      if (model_win.size() == 5) exp_q.push_back(ref_result(model_win));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
    #12;
    total++;
    if (out_valid !== 1'b0 || out_median !== 32'd0 || out_min !== 32'd0 ||
        out_max !== 32'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got v=%b med=%h min=%h max=%h rdy=%b, need 0/0/0/0/1",
               out_valid, out_median, out_min, out_max, in_ready);
    end
    rst = 1'b0;
    step();
  endtask

  // Feed five samples and expect exactly one result two edges after the fifth.
  task automatic fill_and_check(input string name, input logic [31:0] d[5],
                                input logic [31:0] e_med, input logic [31:0] e_min,
                                input logic [31:0] e_max);
    for (int i = 0; i < 5; i++) begin
      push(d[i]);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL %s_underfill: out_valid=%b after accept %0d, need 0", name, out_valid, i);
      end
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL %s_latency1: out_valid=%b one edge after launch, need 0", name, out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_median !== e_med || out_min !== e_min || out_max !== e_max) begin
      bad++;
      $display("FAIL %s_result: got v=%b med=%h min=%h max=%h, need 1 %h %h %h",
               name, out_valid, out_median, out_min, out_max, e_med, e_min, e_max);
    end
  endtask

  task automatic test_fill();
    logic [31:0] d[5];
    d = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    out_ready = 1'b1;
    fill_and_check("fill", d, 32'd30, 32'd10, 32'd50);
  endtask

  task automatic test_slide();
    push(32'd5);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL slide_transfer_drop: out_valid=%b, need 0", out_valid);
    end
    push(32'd60);
    step();
    total++;
    if (out_valid !== 1'b1 || out_median !== 32'd30 || out_min !== 32'd5 || out_max !== 32'd50) begin
      bad++; $display("FAIL slide_5: got v=%b %0d %0d %0d, need 1 30 5 50", out_valid, out_median, out_min, out_max);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_median !== 32'd40 || out_min !== 32'd5 || out_max !== 32'd60) begin
      bad++; $display("FAIL slide_60: got v=%b %0d %0d %0d, need 1 40 5 60", out_valid, out_median, out_min, out_max);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL slide_idle: out_valid=%b, need 0", out_valid);
    end
  endtask

  task automatic test_ties();
    logic [31:0] d[5];
    flush = 1'b1; step(); flush = 1'b0;
    d = '{32'd7, 32'd7, 32'd1, 32'd9, 32'd7};
    fill_and_check("ties", d, 32'd7, 32'd1, 32'd9);
    step();
  endtask

  task automatic test_extremes();
    logic [31:0] d[5];
    flush = 1'b1; step(); flush = 1'b0;
    d = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    fill_and_check("extremes", d, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF);
    step();
  endtask

  task automatic test_flush();
    logic [31:0] d[5];
    flush = 1'b1; step(); flush = 1'b0;
    push(32'd1); push(32'd2); push(32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd99;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready: in_ready=%b during flush, need 0", in_ready);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    d = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500};
    fill_and_check("flush", d, 32'd300, 32'd100, 32'd500);
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] win[$];
    res_t        exp[$];
    res_t        r;
    logic [31:0] d, snap_med, snap_min, snap_max;
    logic        acc;
    int          got = 0;
    int          launched = 0;
    flush = 1'b1; step(); flush = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      d = $urandom;
      in_valid = 1'b1; in_data = d;
      #1;
      acc = in_ready;
      step();
      if (acc) begin
        win.push_back(d);
        if (win.size() > 5) void'(win.pop_front());
        if (win.size() == 5) begin exp.push_back(ref_result(win)); launched++; end
      end
    end
    in_valid = 1'b0;
    snap_med = out_median; snap_min = out_min; snap_max = out_max;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_median !== snap_med ||
          out_min !== snap_min || out_max !== snap_max) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: rdy=%b v=%b med=%h min=%h max=%h, need 0 1 %h %h %h",
                 k, in_ready, out_valid, out_median, out_min, out_max, snap_med, snap_min, snap_max);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid) begin
        got++;
        total++;
        if (exp.size() == 0) begin
          bad++; $display("FAIL bp_extra: result %h with none expected", out_median);
        end else begin
          r = exp.pop_front();
          if (out_median !== r.med || out_min !== r.mn || out_max !== r.mx) begin
            bad++;
            $display("FAIL bp_order: got %h %h %h, need %h %h %h",
                     out_median, out_min, out_max, r.med, r.mn, r.mx);
          end
        end
      end
      step();
    end
    total++;
    if (got !== launched || launched == 0) begin
      bad++; $display("FAIL bp_count: delivered %0d, need %0d (nonzero)", got, launched);
    end
  endtask

  task automatic test_random();
    res_t        r;
    logic        xfer, stalled;
    logic [31:0] p_med, p_min, p_max;
    flush = 1'b1; step(); flush = 1'b0;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = ($urandom_range(1) == 1) ? 32'($urandom_range(7)) : $urandom;
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(59) == 0);
      #1;
      total++;
      if (in_ready !== (!(out_valid && !out_ready) && !flush)) begin
        bad++; $display("FAIL rnd_ready cycle %0d: in_ready=%b, v=%b ordy=%b fl=%b",
                        c, in_ready, out_valid, out_ready, flush);
      end
      xfer    = out_valid && out_ready && !flush;
      stalled = out_valid && !out_ready && !flush;
      p_med = out_median; p_min = out_min; p_max = out_max;
      if (xfer) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_underfill cycle %0d: unexpected result %h", c, out_median);
        end else begin
          r = exp_q.pop_front();
          if (out_median !== r.med || out_min !== r.mn || out_max !== r.mx) begin
            bad++; $display("FAIL rnd_value cycle %0d: got %h %h %h, need %h %h %h",
                            c, out_median, out_min, out_max, r.med, r.mn, r.mx);
          end
        end
      end
      step();
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_median !== p_med || out_min !== p_min || out_max !== p_max) begin
          bad++; $display("FAIL rnd_stall cycle %0d: v=%b outputs changed to %h %h %h from %h %h %h",
                          c, out_valid, out_median, out_min, out_max, p_med, p_min, p_max);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_drain_extra: result %h", out_median);
        end else begin
          r = exp_q.pop_front();
          if (out_median !== r.med || out_min !== r.mn || out_max !== r.mx) begin
            bad++; $display("FAIL rnd_drain_value: got %h %h %h, need %h %h %h",
                            out_median, out_min, out_max, r.med, r.mn, r.mx);
          end
        end
      end
      step();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_lost: %0d results never delivered, need 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d[5];
    flush = 1'b1; step(); flush = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) push(32'(k * 3 + 11));
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_precond: out_valid=%b, need 1", out_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_median !== 32'd0 || out_min !== 32'd0 ||
        out_max !== 32'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_async: v=%b med=%h min=%h max=%h rdy=%b, need 0 0 0 0 1",
                      out_valid, out_median, out_min, out_max, in_ready);
    end
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    d = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    fill_and_check("rstmid", d, 32'd3, 32'd1, 32'd5);
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_ties();
    test_extremes();
    test_flush();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
